// File: rtl/clkgen_pkg.sv
// Shared constants and helpers for the power-of-two clock generator.
// Optional per-channel gating is enabled with the CLKGEN_GATE_EN macro.
package clkgen_pkg;

    localparam int CLKGEN_MAX_OUT = 8;

    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // True when the low idx+1 counter bits are all ones: channel idx ends its period this cycle.
    function automatic logic chan_boundary(input logic [CLKGEN_MAX_OUT-1:0] cnt, input int idx);
        logic [CLKGEN_MAX_OUT-1:0] mask;
        mask = CLKGEN_MAX_OUT'((1 << (idx + 1)) - 1);
        return (cnt & mask) == mask;
    endfunction

endpackage

// File: rtl/clk_gen_multi_chan.sv
// One divided-clock channel: registered clk_div/tick driven from the next counter value.
// With CLKGEN_GATE_EN defined, a gate flop updated at the channel period boundary parks it low.
module clkgen_chan #(
    parameter int IDX = 0
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic [IDX:0] i_cntNext,
`ifdef CLKGEN_GATE_EN
    input  logic         i_boundary,
    input  logic         i_gateEn,
`endif
    output logic         o_divNext,
    output logic         o_clkDiv,
    output logic         o_tick
);

    localparam logic [IDX:0] TICK_PAT = (IDX + 1)'(1) << IDX;

    logic w_gateNext;
    logic w_tickNext;

`ifdef CLKGEN_GATE_EN
    logic r_gateQ;

    assign w_gateNext = i_boundary ? i_gateEn : r_gateQ;

    always_ff @(posedge i_clk) begin
        if (i_reset) r_gateQ <= 1'b1;
        else         r_gateQ <= w_gateNext;
    end
`else
    assign w_gateNext = 1'b1;
`endif

    assign o_divNext  = i_cntNext[IDX] & w_gateNext;
    assign w_tickNext = (i_cntNext == TICK_PAT) & w_gateNext;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_clkDiv <= 1'b0;
            o_tick   <= 1'b0;
        end else begin
            o_clkDiv <= o_divNext;
            o_tick   <= w_tickNext;
        end
    end

endmodule

// File: rtl/clk_gen_multi.sv
// Power-of-two clock generator: NUM_OUT divided clocks, rising-edge ticks, glitch-free muxed output, lock flag.
// Define CLKGEN_GATE_EN to add the per-channel i_gateEn input.
module clk_gen_multi
    import clkgen_pkg::*;
#(
    parameter int NUM_OUT = 4,
    parameter int SEL_W   = sel_width(NUM_OUT),
    parameter int SEL_RST = 0
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [SEL_W-1:0]   i_sel,
`ifdef CLKGEN_GATE_EN
    input  logic [NUM_OUT-1:0] i_gateEn,
`endif
    output logic [NUM_OUT-1:0] o_clkDiv,
    output logic [NUM_OUT-1:0] o_tick,
    output logic               o_clkOut,
    output logic               o_selPending,
    output logic               o_locked
);

    logic [NUM_OUT-1:0] r_cnt;
    logic [SEL_W-1:0]   r_selQ;

    logic [NUM_OUT-1:0] w_cntNext;
    logic [NUM_OUT-1:0] w_divNext;
    logic               w_wrap;
    logic               w_selLegal;
    logic [SEL_W-1:0]   w_selQNext;
    logic               w_clkOutNext;
    logic               w_selPendingNext;
    logic               w_lockedNext;

    assign w_cntNext  = r_cnt + NUM_OUT'(1);
    assign w_wrap     = &r_cnt;
    assign w_selLegal = ({1'b0, i_sel} < (SEL_W + 1)'(NUM_OUT));

    // The select only moves at the all-ones boundary, where every channel is about to go low.
    assign w_selQNext       = (w_wrap && w_selLegal) ? i_sel : r_selQ;
    assign w_selPendingNext = w_selLegal && (i_sel != w_selQNext);
    assign w_lockedNext     = o_locked | w_wrap;

    genvar g;
    generate
        for (g = 0; g < NUM_OUT; g++) begin : gen_chan
            clkgen_chan #(.IDX(g)) u_chan (
                .i_clk      (i_clk),
                .i_reset    (i_reset),
                .i_cntNext  (w_cntNext[g:0]),
`ifdef CLKGEN_GATE_EN
                .i_boundary (chan_boundary(CLKGEN_MAX_OUT'(r_cnt), g)),
                .i_gateEn   (i_gateEn[g]),
`endif
                .o_divNext  (w_divNext[g]),
                .o_clkDiv   (o_clkDiv[g]),
                .o_tick     (o_tick[g])
            );
        end
    endgenerate

    always_comb begin
        w_clkOutNext = 1'b0;
        for (int i = 0; i < NUM_OUT; i++) begin
            if (w_selQNext == SEL_W'(i)) w_clkOutNext = w_divNext[i];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt        <= '0;
            r_selQ       <= SEL_W'(SEL_RST);
            o_clkOut     <= 1'b0;
            o_selPending <= 1'b0;
            o_locked     <= 1'b0;
        end else begin
            r_cnt        <= w_cntNext;
            r_selQ       <= w_selQNext;
            o_clkOut     <= w_clkOutNext;
            o_selPending <= w_selPendingNext;
            o_locked     <= w_lockedNext;
        end
    end

endmodule

// File: tb/tb_clk_gen_multi.sv
// Self-checking bench for clk_gen_multi: directed vector table, hand sequences and a random run
// against a cycle-count reference model. Gating checks are compiled in with CLKGEN_GATE_EN.
module tb_clk_gen_multi;

    localparam int N    = 4;
    localparam int SW   = 3;
    localparam int SRST = 0;
    localparam int P    = 1 << N;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [SW-1:0] sel = '0;
    logic [N-1:0]  clkDiv;
    logic [N-1:0]  tick;
    logic          clkOut;
    logic          selPending;
    logic          locked;
`ifdef CLKGEN_GATE_EN
    logic [N-1:0]  gateEn = '1;
`endif

    clk_gen_multi #(.NUM_OUT(N), .SEL_W(SW), .SEL_RST(SRST)) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_sel        (sel),
`ifdef CLKGEN_GATE_EN
        .i_gateEn     (gateEn),
`endif
        .o_clkDiv     (clkDiv),
        .o_tick       (tick),
        .o_clkOut     (clkOut),
        .o_selPending (selPending),
        .o_locked     (locked)
    );

    always #5 clk = ~clk;

    int nCompared = 0;
    int nMismatched = 0;

    // Reference model: cycles since reset, and the channel currently applied to clk_out.
    int k = 0;
    int applied = SRST;
    bit pendM = 1'b0;

    typedef struct {
        bit         rst;
        logic [2:0] sel;
        int         cycles;
        logic [3:0] div;
        logic [3:0] tck;
        bit         out;
        bit         pend;
        bit         lock;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [N-1:0] expDiv(input int kk);
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = (kk % (2 << i)) >= (1 << i);
        return r;
    endfunction

    function automatic logic [N-1:0] expTick(input int kk);
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = (kk % (2 << i)) == (1 << i);
        return r;
    endfunction

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        logic [N-1:0] d;
        d = expDiv(k);
        checkVal({tag, " clk_div"}, 32'(clkDiv), 32'(d));
        checkVal({tag, " tick"}, 32'(tick), 32'(expTick(k)));
        checkVal({tag, " clk_out"}, 32'(clkOut), 32'(d[applied]));
        checkVal({tag, " sel_pending"}, 32'(selPending), 32'(pendM));
        checkVal({tag, " locked"}, 32'(locked), 32'(k >= P));
    endtask

    task automatic applyStimulus(input bit r, input logic [SW-1:0] s, input bit chk);
        reset = r;
        sel   = s;
        @(posedge clk);
        if (r) begin
            k       = 0;
            applied = SRST;
            pendM   = 1'b0;
        end else begin
            if ((k % P) == P - 1 && int'(s) < N) applied = int'(s);
            k++;
            pendM = (int'(s) < N) && (int'(s) != applied);
        end
        @(negedge clk);
        if (chk) checkOutput($sformatf("k=%0d", k));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int tick3Cnt;
        int highCnt[N];
        int misaligned;
        logic [N-1:0] prevDiv;

        vecs.push_back('{1'b1, 3'd0, 2,  4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 3'd0, 1,  4'b0001, 4'b0001, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 3'd0, 1,  4'b0010, 4'b0010, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 3'd0, 2,  4'b0100, 4'b0100, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 3'd0, 1,  4'b0101, 4'b0001, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 3'd3, 1,  4'b0110, 4'b0010, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 3'd3, 2,  4'b1000, 4'b1000, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 3'd5, 7,  4'b1111, 4'b0001, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 3'd3, 1,  4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 3'd3, 8,  4'b1000, 4'b1000, 1'b1, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 3'd5, 8,  4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 3'd5, 5,  4'b0101, 4'b0001, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{1'b1, 3'd5, 1,  4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 3'd0, 15, 4'b1111, 4'b0001, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 3'd0, 1,  4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 3'd1, 16, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 3'd1, 2,  4'b0010, 4'b0010, 1'b1, 1'b0, 1'b1});

        foreach (vecs[i]) begin
            for (int c = 0; c < vecs[i].cycles; c++) applyStimulus(vecs[i].rst, vecs[i].sel, 1'b1);
            checkVal($sformatf("vec%0d clk_div", i), 32'(clkDiv), 32'(vecs[i].div));
            checkVal($sformatf("vec%0d tick", i), 32'(tick), 32'(vecs[i].tck));
            checkVal($sformatf("vec%0d clk_out", i), 32'(clkOut), 32'(vecs[i].out));
            checkVal($sformatf("vec%0d sel_pending", i), 32'(selPending), 32'(vecs[i].pend));
            checkVal($sformatf("vec%0d locked", i), 32'(locked), 32'(vecs[i].lock));
        end

        // 64 cycles after reset: tick width/alignment, tick[3] count and 50% duty.
        applyStimulus(1'b1, '0, 1'b1);
        tick3Cnt = 0;
        misaligned = 0;
        foreach (highCnt[i]) highCnt[i] = 0;
        prevDiv = clkDiv;
        for (int c = 0; c < 64; c++) begin
            applyStimulus(1'b0, '0, 1'b1);
            for (int i = 0; i < N; i++) begin
                if (clkDiv[i]) highCnt[i]++;
                if (tick[i] && !(clkDiv[i] && !prevDiv[i])) misaligned++;
                if (!tick[i] && clkDiv[i] && !prevDiv[i]) misaligned++;
            end
            if (tick[3]) tick3Cnt++;
            prevDiv = clkDiv;
        end
        checkVal("tick3 count", 32'(tick3Cnt), 32'd4);
        checkVal("tick alignment errors", 32'(misaligned), 32'd0);
        for (int i = 0; i < N; i++) checkVal($sformatf("duty ch%0d", i), 32'(highCnt[i]), 32'd32);

`ifdef CLKGEN_GATE_EN
        // Gate channel 2 at cycle 3, re-enable at cycle 20.
        applyStimulus(1'b1, '0, 1'b0);
        for (int c = 1; c <= 40; c++) begin
            applyStimulus(1'b0, '0, 1'b0);
            checkVal($sformatf("gate k=%0d clk_div2", c), 32'(clkDiv[2]),
                     32'(((c >= 4) && (c <= 7)) || ((c >= 28) && ((c % 8) >= 4))));
            if (c == 3)  gateEn[2] = 1'b0;
            if (c == 20) gateEn[2] = 1'b1;
        end
`endif

        // Random select activity with occasional resets, checked every cycle.
        applyStimulus(1'b1, '0, 1'b1);
        begin
            logic [SW-1:0] s;
            s = '0;
            for (int c = 0; c < 400; c++) begin
                if ($urandom_range(0, 5) == 0) s = SW'($urandom_range(0, 7));
                applyStimulus($urandom_range(0, 59) == 0, s, 1'b1);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
